// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and index-width helper for the PISO transmitter
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
endpackage

// File: rtl/piso_tx.sv
// piso_tx: valid/ready parallel-in serial-out transmitter with frame markers and gapless reload
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);
    localparam int IW = idx_w(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
    state_t state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [IW-1:0] idx_q, idx_d;
    logic last, step, accept;
    // handshake, next state and shift datapath; the last-bit edge can accept a new word
    always_comb begin
        last = (idx_q == LAST);
        step = (state_q == SHIFT) && shift_en;
        din_ready = !rst && ((state_q == IDLE) || (step && last));
        accept = din_valid && din_ready;
        state_d = accept ? SHIFT : (step && last) ? IDLE : state_q;
        sreg_d = accept ? din : !step ? sreg_q : MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
        idx_d = (accept || (step && last)) ? '0 : step ? idx_q + IW'(1) : idx_q;
    end
    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // shift register, zero-filled as bits leave
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sreg_q <= '0;
        else     sreg_q <= sreg_d;
    end
    // bit index within the current word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end
    // outputs decode only from flops, so they move on the clock edge or on reset
    always_comb begin
        busy = (state_q == SHIFT);
        dout_valid = busy;
        dout = busy && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
        frame_start = busy && (idx_q == '0);
        frame_end = busy && (idx_q == LAST);
    end
endmodule
